// File: rtl/spi_seq_pkg.sv
// Shared types and width constants for the SPI transfer sequencer.
package spi_seq_pkg;

    // DATA_W of any instance must not exceed SPI_MAX_DATA_W.
    localparam int SPI_MAX_DATA_W = 32;
    localparam int SPI_MAX_LEN_W  = $clog2(SPI_MAX_DATA_W + 1);
    localparam int SPI_MAX_CS_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    typedef struct packed {
        logic [SPI_MAX_DATA_W-1:0] data;
        logic [SPI_MAX_LEN_W-1:0]  len;
        logic [SPI_MAX_CS_W-1:0]   cs;
        logic                      cpol;
        logic                      cpha;
    } spi_cmd_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_seq_shifter.sv
// TX/RX shift registers for the SPI sequencer; the RX half exists only
// when SPI_SEQ_RX_EN is defined.
module spi_seq_shifter #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_shift,
    input  logic              i_miso,
    output logic              o_mosi
`ifdef SPI_SEQ_RX_EN
    ,
    output logic [DATA_W-1:0] o_rx
`endif
);

    logic [DATA_W-1:0] r_tx;

    always_ff @(posedge i_clk) begin
        if (i_rst)        r_tx <= '0;
        else if (i_load)  r_tx <= i_data;
        else if (i_shift) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
    end

    assign o_mosi = r_tx[DATA_W-1];

`ifdef SPI_SEQ_RX_EN
    logic [DATA_W-1:0] r_rx;

    // Cleared on load so short transfers come back right-justified with zero upper bits.
    always_ff @(posedge i_clk) begin
        if (i_rst)        r_rx <= '0;
        else if (i_load)  r_rx <= '0;
        else if (i_shift) r_rx <= {r_rx[DATA_W-2:0], i_miso};
    end

    assign o_rx = r_rx;
`else
    logic w_unused_miso;
    assign w_unused_miso = i_miso;
`endif

endmodule

// File: rtl/spi_transfer_sequencer.sv
// Command-driven SPI transfer FSM: SETUP -> SHIFT -> HOLD -> GAP with one shared
// phase counter. Define SPI_SEQ_RX_EN to build MISO capture; otherwise rsp_data is 0.
module spi_transfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int CS_N      = 4,
    parameter  int SETUP_CYC = 2,
    parameter  int HOLD_CYC  = 2,
    parameter  int GAP_CYC   = 1,
    localparam int LEN_W     = $clog2(DATA_W + 1),
    localparam int CS_W      = (CS_N > 1) ? $clog2(CS_N) : 1
) (
    input  logic              clk_0,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [CS_W-1:0]   cmd_cs,
    input  logic              cmd_cpol,
    input  logic              cmd_cpha,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              cpol,
    output logic              cpha,
    output logic              sclk_en,
    output logic [CS_N-1:0]   cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int CNT_W = $clog2(max_int(max_int(SETUP_CYC, HOLD_CYC),
                                          max_int(GAP_CYC, DATA_W)) + 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic              r_ready, r_busy, r_cpol, r_cpha, r_sclk_en, r_rsp_valid;
    logic [CS_N-1:0]   r_cs_n;

    spi_cmd_t          w_cmd;
    logic [LEN_W-1:0]  w_len;
    logic [CS_N-1:0]   w_cs_sel;
    logic              w_accept, w_cnt_done, w_shift, w_done, w_tx_msb;

    // Normalise the command: left-justify data, clamp length, decode CS (out-of-range selects none).
    always_comb begin
        w_cmd      = '0;
        w_cmd.data = SPI_MAX_DATA_W'(cmd_data) << (SPI_MAX_DATA_W - DATA_W);
        w_cmd.len  = SPI_MAX_LEN_W'(cmd_len);
        w_cmd.cs   = SPI_MAX_CS_W'(cmd_cs);
        w_cmd.cpol = cmd_cpol;
        w_cmd.cpha = cmd_cpha;
        w_len = (w_cmd.len > SPI_MAX_LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : LEN_W'(w_cmd.len);
        for (int i = 0; i < CS_N; i++) w_cs_sel[i] = (w_cmd.cs == SPI_MAX_CS_W'(i));
    end

    assign w_accept   = (r_state == IDLE) && r_ready && cmd_valid;
    assign w_cnt_done = (r_cnt == '0);
    assign w_shift    = (r_state == SHIFT);
    assign w_done     = (r_state == HOLD) && w_cnt_done;

    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_sclk_en   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cs_n      <= '1;
        end else begin
            r_rsp_valid <= 1'b0;
            if (!w_cnt_done) r_cnt <= r_cnt - CNT_W'(1);
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_state <= SETUP;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cpol  <= w_cmd.cpol;
                        r_cpha  <= w_cmd.cpha;
                        r_len   <= w_len;
                        r_cs_n  <= ~w_cs_sel;
                        r_cnt   <= CNT_W'(SETUP_CYC - 1);
                    end
                end
                SETUP: if (w_cnt_done) begin
                    if (r_len == '0) begin
                        r_state <= HOLD;
                        r_cnt   <= CNT_W'(HOLD_CYC - 1);
                    end else begin
                        r_state   <= SHIFT;
                        r_sclk_en <= 1'b1;
                        r_cnt     <= CNT_W'(r_len - LEN_W'(1));
                    end
                end
                SHIFT: if (w_cnt_done) begin
                    r_state   <= HOLD;
                    r_sclk_en <= 1'b0;
                    r_cnt     <= CNT_W'(HOLD_CYC - 1);
                end
                HOLD: if (w_cnt_done) begin
                    r_state     <= GAP;
                    r_cs_n      <= '1;
                    r_rsp_valid <= 1'b1;
                    r_cnt       <= CNT_W'(GAP_CYC - 1);
                end
                GAP: if (w_cnt_done) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SEQ_RX_EN
    logic [DATA_W-1:0] w_rx;
    logic [DATA_W-1:0] r_rsp_data;
`endif

    spi_seq_shifter #(.DATA_W(DATA_W)) u_shifter (
        .i_clk   (clk_0),
        .i_rst   (rst),
        .i_load  (w_accept),
        .i_data  (w_cmd.data[SPI_MAX_DATA_W-1 -: DATA_W]),
        .i_shift (w_shift),
        .i_miso  (miso),
        .o_mosi  (w_tx_msb)
`ifdef SPI_SEQ_RX_EN
        ,
        .o_rx    (w_rx)
`endif
    );

`ifdef SPI_SEQ_RX_EN
    always_ff @(posedge clk_0) begin
        if (rst)         r_rsp_data <= '0;
        else if (w_done) r_rsp_data <= w_rx;
    end
    assign rsp_data = r_rsp_data;
`else
    assign rsp_data = '0;
`endif

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign busy      = r_busy;
    assign cpol      = r_cpol;
    assign cpha      = r_cpha;
    assign sclk_en   = r_sclk_en;
    assign cs_n      = r_cs_n;
    assign mosi      = r_sclk_en & w_tx_msb;

endmodule

// File: tb/tb_spi_transfer_sequencer.sv
// Directed bench for spi_transfer_sequencer: CS_N=4 instance in MISO loopback,
// plus a CS_N=8 instance for chip-select decode.
module tb_spi_transfer_sequencer;

`ifdef SPI_SEQ_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        clk_0 = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_cpol, cmd_cpha;
    logic [31:0] cmd_data;
    logic [5:0]  cmd_len;
    logic [1:0]  cmd_cs;
    logic        cmd_ready, rsp_valid, busy, cpol, cpha, sclk_en, mosi, miso;
    logic [31:0] rsp_data;
    logic [3:0]  cs_n;

    logic        e_cmd_valid, e_cmd_cpol, e_cmd_cpha;
    logic [31:0] e_cmd_data;
    logic [5:0]  e_cmd_len;
    logic [2:0]  e_cmd_cs;
    logic        e_cmd_ready, e_rsp_valid, e_busy, e_cpol, e_cpha, e_sclk_en, e_mosi, e_miso;
    logic [31:0] e_rsp_data;
    logic [7:0]  e_cs_n;

    int checks = 0;
    int errors = 0;

    always #5 clk_0 = ~clk_0;
    assign miso   = mosi;
    assign e_miso = e_mosi;

    spi_transfer_sequencer dut (
        .clk_0(clk_0), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_cs(cmd_cs), .cmd_cpol(cmd_cpol),
        .cmd_cpha(cmd_cpha), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .cpol(cpol), .cpha(cpha), .sclk_en(sclk_en), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_transfer_sequencer #(.CS_N(8)) dut8 (
        .clk_0(clk_0), .rst(rst), .cmd_valid(e_cmd_valid), .cmd_ready(e_cmd_ready),
        .cmd_data(e_cmd_data), .cmd_len(e_cmd_len), .cmd_cs(e_cmd_cs), .cmd_cpol(e_cmd_cpol),
        .cmd_cpha(e_cmd_cpha), .rsp_valid(e_rsp_valid), .rsp_data(e_rsp_data), .busy(e_busy),
        .cpol(e_cpol), .cpha(e_cpha), .sclk_en(e_sclk_en), .cs_n(e_cs_n), .mosi(e_mosi), .miso(e_miso)
    );

    task automatic wait_ready(input bit eight);
        for (int i = 0; i < 64 && ((eight ? e_cmd_ready : cmd_ready) !== 1'b1); i++) @(negedge clk_0);
        checks++;
        if ((eight ? e_cmd_ready : cmd_ready) !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready eight=%0d got=0 exp=1", eight);
        end
    endtask

    task automatic issue(input logic [31:0] d, input logic [5:0] l, input logic [1:0] cs,
                         input logic pol, input logic pha);
        cmd_data = d; cmd_len = l; cmd_cs = cs; cmd_cpol = pol; cmd_cpha = pha;
        cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst = 1'b1;
        cmd_valid = 0; cmd_data = 0; cmd_len = 0; cmd_cs = 0; cmd_cpol = 0; cmd_cpha = 0;
        e_cmd_valid = 0; e_cmd_data = 0; e_cmd_len = 0; e_cmd_cs = 0; e_cmd_cpol = 0; e_cmd_cpha = 0;
        repeat (3) @(negedge clk_0);
        got = {cmd_ready, rsp_valid, busy, cpol, cpha, sclk_en, cs_n, mosi};
        checks++;
        if (got !== 11'b000000_1111_0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", got, 11'b000000_1111_0);
        end
        checks++;
        if (rsp_data !== 32'h0 || e_cs_n !== 8'hFF) begin
            errors++; $display("FAIL reset_data got=%h/%h exp=0/ff", rsp_data, e_cs_n);
        end
        rst = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low got=%b exp=0", cmd_ready);
        end
        @(negedge clk_0);
        checks++;
        if (cmd_ready !== 1'b1 || e_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_high got=%b%b exp=11", cmd_ready, e_cmd_ready);
        end
    endtask

    task automatic test_mode3();
        logic [9:0] got, exp;
        wait_ready(0);
        checks++;
        if (cpol !== 1'b0 || cpha !== 1'b0) begin
            errors++; $display("FAIL mode3_pre got=%b%b exp=00", cpol, cpha);
        end
        issue(32'h12345678, 6'd32, 2'd0, 1'b1, 1'b1);
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk_0);
            if (c == 1) cmd_valid = 1'b0;
            got = {cpol, cpha, cs_n, sclk_en, rsp_valid, busy, cmd_ready};
            exp = {1'b1, 1'b1, (c <= 36) ? 4'b1110 : 4'b1111, (c >= 3 && c <= 34),
                   (c == 37), (c <= 37), (c == 38)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL mode3 c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 37) begin
                checks++;
                if (rsp_data !== (RX_EN ? 32'h12345678 : 32'h0)) begin
                    errors++; $display("FAIL mode3_data got=%h exp=%h", rsp_data, RX_EN ? 32'h12345678 : 32'h0);
                end
            end
        end
    endtask

    task automatic test_mode0();
        logic [31:0] tx;
        logic [10:0] got, exp;
        tx = 32'hA5000000;
        wait_ready(0);
        checks++;
        if (cpol !== 1'b1 || cpha !== 1'b1) begin
            errors++; $display("FAIL mode0_held_pol got=%b%b exp=11", cpol, cpha);
        end
        issue(tx, 6'd8, 2'd1, 1'b0, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk_0);
            if (c == 1) cmd_valid = 1'b0;
            got = {cpol, cpha, cs_n, sclk_en, rsp_valid, busy, cmd_ready, mosi};
            exp = {2'b00, (c <= 12) ? 4'b1101 : 4'b1111, (c >= 3 && c <= 10), (c == 13),
                   (c <= 13), (c == 14), (c >= 3 && c <= 10) ? tx[34-c] : 1'b0};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL mode0 c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 13) begin
                checks++;
                if (rsp_data !== (RX_EN ? 32'hA5 : 32'h0)) begin
                    errors++; $display("FAIL mode0_data got=%h exp=%h", rsp_data, RX_EN ? 32'hA5 : 32'h0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        wait_ready(0);
        issue(32'h3C000000, 6'd8, 2'd1, 1'b0, 1'b0);
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk_0);
            if (c == 1) issue(32'hC3000000, 6'd8, 2'd1, 1'b0, 1'b0);
            if (c == 15) cmd_valid = 1'b0;
            got = {cs_n, sclk_en, rsp_valid, busy, cmd_ready};
            exp = {((c <= 12) || (c >= 15 && c <= 26)) ? 4'b1101 : 4'b1111,
                   (c >= 3 && c <= 10) || (c >= 17 && c <= 24),
                   (c == 13) || (c == 27), (c != 14 && c != 28), (c == 14 || c == 28)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL b2b c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 13 || c == 27) begin
                checks++;
                if (rsp_data !== (!RX_EN ? 32'h0 : (c == 13) ? 32'h3C : 32'hC3)) begin
                    errors++; $display("FAIL b2b_data c=%0d got=%h", c, rsp_data);
                end
            end
        end
    endtask

    task automatic test_len_zero();
        logic [7:0] got, exp;
        wait_ready(0);
        issue(32'hFFFFFFFF, 6'd0, 2'd2, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_0);
            if (c == 1) cmd_valid = 1'b0;
            got = {cs_n, sclk_en, rsp_valid, mosi, cmd_ready};
            exp = {(c <= 4) ? 4'b1011 : 4'b1111, 1'b0, (c == 5), 1'b0, (c == 6)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL len0 c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 5) begin
                checks++;
                if (rsp_data !== 32'h0) begin
                    errors++; $display("FAIL len0_data got=%h exp=0", rsp_data);
                end
            end
        end
    endtask

    task automatic test_len_clamp();
        logic [1:0] got, exp;
        wait_ready(0);
        issue(32'hFFFFFFFF, 6'd40, 2'd0, 1'b0, 1'b1);
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk_0);
            if (c == 1) cmd_valid = 1'b0;
            got = {sclk_en, rsp_valid};
            exp = {(c >= 3 && c <= 34), (c == 37)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL clamp c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 37) begin
                checks++;
                if (rsp_data !== (RX_EN ? 32'hFFFFFFFF : 32'h0)) begin
                    errors++; $display("FAIL clamp_data got=%h", rsp_data);
                end
            end
        end
    endtask

    task automatic test_cs_decode();
        logic [8:0] got8, exp8;
        wait_ready(0);
        issue(32'h0, 6'd0, 2'd3, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_0);
            if (c == 1) cmd_valid = 1'b0;
            checks++;
            if (cs_n !== ((c <= 4) ? 4'b0111 : 4'b1111)) begin
                errors++; $display("FAIL cs3 c=%0d got=%b", c, cs_n);
            end
        end
        wait_ready(1);
        e_cmd_data = 32'h80000000; e_cmd_len = 6'd8; e_cmd_cs = 3'd5;
        e_cmd_cpol = 1'b0; e_cmd_cpha = 1'b0; e_cmd_valid = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk_0);
            if (c == 1) e_cmd_valid = 1'b0;
            got8 = {e_cs_n, e_rsp_valid};
            exp8 = {(c <= 12) ? 8'b1101_1111 : 8'hFF, (c == 13)};
            checks++;
            if (got8 !== exp8) begin
                errors++; $display("FAIL cs5_n8 c=%0d got=%b exp=%b", c, got8, exp8);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [10:0] got;
        bit          saw_rsp;
        wait_ready(0);
        issue(32'hFF000000, 6'd8, 2'd0, 1'b1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_0);
            if (c == 1) cmd_valid = 1'b0;
        end
        checks++;
        if ({cs_n, sclk_en, cpol} !== 6'b1110_1_1) begin
            errors++; $display("FAIL midrst_pre got=%b exp=111011", {cs_n, sclk_en, cpol});
        end
        rst = 1'b1;
        @(negedge clk_0);
        rst = 1'b0;
        got = {cmd_ready, rsp_valid, busy, cpol, cpha, sclk_en, cs_n, mosi};
        checks++;
        if (got !== 11'b000000_1111_0) begin
            errors++; $display("FAIL midrst_outputs got=%b exp=%b", got, 11'b000000_1111_0);
        end
        @(negedge clk_0);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_ready got=%b exp=1", cmd_ready);
        end
        saw_rsp = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
            @(negedge clk_0);
        end
        checks++;
        if (saw_rsp) begin
            errors++; $display("FAIL midrst_no_rsp got=1 exp=0");
        end
    endtask

    initial begin
        test_reset();
        test_mode3();
        test_mode0();
        test_back_to_back();
        test_len_zero();
        test_len_clamp();
        test_cs_decode();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_transfer_sequencer.md
# spi_transfer_sequencer

Command-driven SPI transfer controller running on the 0° system clock. Accepts one transfer command at a time and latches the per-transfer clock polarity and phase for the downstream SPI clock generator. Sequences chip-select setup, bit shifting, hold and inter-transfer gap, then returns received data. Sits between the host register/command interface and the SPI pads.

## Interface
- `DATA_W`, 32: maximum bits per transfer.
- `CS_N`, 4: number of chip-select lines.
- `SETUP_CYC`, 2: CS-asserted cycles before the first bit; must be ≥1.
- `HOLD_CYC`, 2: CS-asserted cycles after the last bit; must be ≥1.
- `GAP_CYC`, 1: CS-deasserted cycles before the next accept; must be ≥1.

- `clk_0` in 1: system clock, 0° phase. Sole clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accept; transfer when `cmd_valid && cmd_ready`.
- `cmd_data` in DATA_W: TX word, MSB-first, left-justified.
- `cmd_len` in $clog2(DATA_W+1): bit count, 0..DATA_W.
- `cmd_cs` in $clog2(CS_N) (min 1): chip-select index.
- `cmd_cpol` in 1: clock polarity for this transfer.
- `cmd_cpha` in 1: clock phase for this transfer.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out DATA_W: RX bits, right-justified, upper bits zero.
- `busy` out 1: high in every state except IDLE.
- `cpol` out 1: latched polarity to clock generator.
- `cpha` out 1: latched phase to clock generator.
- `sclk_en` out 1: SPI clock gate, high only in SHIFT.
- `cs_n` out CS_N: active-low chip selects.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.

## Operation
- FSM: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: `cmd_ready`=1. On accept, latch data, len, cs, `cpol`/`cpha` (registered on the accept edge), then go to SETUP.
- SETUP: `cs_n[cmd_cs]`=0 for SETUP_CYC cycles. Go to SHIFT, or to HOLD directly if len==0.
- SHIFT: len cycles, `sclk_en`=1.
  - `mosi` = current TX MSB. TX register shifts left each cycle.
  - `miso` is captured into the RX register LSB on the rising edge ending each SHIFT cycle.
- HOLD: CS stays low for HOLD_CYC cycles, `sclk_en`=0, `mosi`=0.
- GAP: all `cs_n`=1 for GAP_CYC cycles. `rsp_valid`=1 in the first GAP cycle only, with `rsp_data` valid. `rsp_data` holds until the next completion.
- `cpol`/`cpha` are held from accept until the next accept. They never change while any CS is asserted.
- `cmd_len` > DATA_W is clamped to DATA_W.
- `cmd_cs` ≥ CS_N: no CS asserted; the transfer otherwise runs normally.
- len==0: no SHIFT phase; `rsp_data`=0.

## Timing
- Reset values: `cmd_ready`=0 while `rst`=1, then 1 on the first cycle after reset. `rsp_valid`=0, `rsp_data`=0, `busy`=0, `cpol`=0, `cpha`=0, `sclk_en`=0, `cs_n`=all ones, `mosi`=0.
- Cycle numbering: accept edge = cycle 0.
  - SETUP occupies cycles 1..SETUP_CYC.
  - SHIFT occupies the next len cycles.
  - HOLD occupies the next HOLD_CYC cycles.
  - `rsp_valid` fires in cycle 1+SETUP_CYC+len+HOLD_CYC.
  - `cmd_ready` returns GAP_CYC cycles after that.
- Back-to-back: with `cmd_valid` held, the next accept occurs in the first cycle `cmd_ready` is high. There are no bubbles beyond GAP.
- `rst` mid-transfer: all outputs reach reset values at the next edge. No `rsp_valid` is issued for the aborted transfer.
- `cmd_valid` while busy is ignored. The command must be held by the source.

## Configuration
- `SPI_SEQ_RX_EN` defined: MISO capture path and RX register are built; `rsp_data` behaves as above.
- `SPI_SEQ_RX_EN` undefined:
  - `miso` is ignored and no RX register is built.
  - `rsp_data` is tied to 0.
  - `rsp_valid` still marks completion.
  - All timing is unchanged.

## Structure
- Package `spi_seq_pkg` holds:
  - the `state_t` enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - the `spi_cmd_t` struct (data, len, cs, cpol, cpha);
  - the width helper constants.
- Sub-module `spi_seq_shifter` holds the TX/RX shift registers. It has parallel load, a shift enable and `miso`/`mosi` ports. The RX half sits under `SPI_SEQ_RX_EN`.
- The top level holds the FSM, the phase counter (shared across SETUP/SHIFT/HOLD/GAP) and the CS decode.

## Test plan
- Mode 0 loopback (`miso`=`mosi`), defaults, data=0xA5000000, len=8, cs=1 → `cs_n`=4'b1101 in cycles 1–12, `sclk_en` in cycles 3–10, `rsp_valid` in cycle 13, `rsp_data`=0x000000A5, `cmd_ready` in cycle 14.
- Mode 3, len=32, data=0x12345678 → `cpol`=`cpha`=1 from cycle 1 through idle; `rsp_data`=0x12345678 in cycle 37.
- Back-to-back: two commands with `cmd_valid` held → second accepted in cycle 14, first `rsp_valid` in cycle 13, second in cycle 27.
- len=0, cs=2 → `cs_n`=4'b1011 in cycles 1–4, `sclk_en` never high, `rsp_valid` in cycle 5, `rsp_data`=0.
- cs=5 with CS_N=8 → `cs_n`[5] low only. With CS_N=4, cs=3 works and `cs_n` never drives index 4+.
- `rst` pulsed in cycle 6 of a len=8 transfer → next cycle all `cs_n`=1, `sclk_en`=0, no `rsp_valid`, `cmd_ready`=1 one cycle after `rst` falls.
